sram_mem_controller: RTL and testbench

- Sequences MEM-stage loads and stores onto the board's external 16-bit asynchronous SRAM.
- Each 32-bit word access is split into two half-word SRAM cycles: low half, then high half.
- Drives `ready` low while a transfer is in flight. The hazard/freeze logic uses it to stall all pipeline registers, so forwarding sources stay stable until the access completes.

---
 rtl/sram_mem_controller.sv | 129 ++++++++++++
 tb/tb_sram_mem_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as two
// half-word cycles (low then high), holding ready low to freeze the pipeline meanwhile.
module sram_mem_controller #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int              CW      = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]   LAST    = CW'(WAIT_CYCLES);
  localparam logic [18:0]     BASE_LO = 19'(ADDR_BASE);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_is_wr;
  logic [16:0]   r_word;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;

  logic [18:0]   w_off;
  logic          w_req;
  logic          w_last;
  logic          w_unused;

  // Only offset bits [18:2] reach the SRAM, so the subtraction is done on the low 19 bits.
  assign w_off    = address[18:0] - BASE_LO;
  assign w_req    = rd_en | wr_en;
  assign w_last   = (r_cnt == LAST);
  assign w_unused = ^{address[31:19], w_off[1:0]};

  assign read_data = r_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_is_wr <= 1'b0;
      r_word  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state <= S_LO;
            r_cnt   <= '0;
            r_is_wr <= wr_en;
            r_word  <= w_off[18:2];
            r_wdata <= write_data;
          end
        end
        S_LO: begin
          if (w_last) begin
            r_state <= S_HI;
            r_cnt   <= '0;
            if (!r_is_wr) r_rdata[15:0] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HI: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            if (!r_is_wr) r_rdata[31:16] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    case (r_state)
      S_IDLE: ready = ~w_req;
      S_LO: begin
        sram_addr = {r_word, 1'b0};
        if (r_is_wr) begin
          sram_dq_out = r_wdata[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      S_HI: begin
        sram_addr = {r_word, 1'b1};
        if (r_is_wr) begin
          sram_dq_out = r_wdata[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      default: ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench: two controllers (WAIT_CYCLES=1 and 0), each with a behavioural
// SRAM, checked against a word-level reference memory and latency rule.
module tb_sram_mem_controller;

  localparam int BASE = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT 0: WAIT_CYCLES = 1
  logic        wr_en0, rd_en0;
  logic [31:0] address0, write_data0, read_data0;
  logic        ready0;
  logic [17:0] sram_addr0;
  logic [15:0] dq_in0, dq_out0;
  logic        dq_oe0, we_n0, oe_n0;

  // DUT 1: WAIT_CYCLES = 0
  logic        wr_en1, rd_en1;
  logic [31:0] address1, write_data1, read_data1;
  logic        ready1;
  logic [17:0] sram_addr1;
  logic [15:0] dq_in1, dq_out1;
  logic        dq_oe1, we_n1, oe_n1;

  sram_mem_controller #(.ADDR_BASE(BASE), .WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0), .address(address0),
    .write_data(write_data0), .read_data(read_data0), .ready(ready0),
    .sram_addr(sram_addr0), .sram_dq_in(dq_in0), .sram_dq_out(dq_out0),
    .sram_dq_oe(dq_oe0), .sram_we_n(we_n0), .sram_oe_n(oe_n0)
  );

  sram_mem_controller #(.ADDR_BASE(BASE), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
    .write_data(write_data1), .read_data(read_data1), .ready(ready1),
    .sram_addr(sram_addr1), .sram_dq_in(dq_in1), .sram_dq_out(dq_out1),
    .sram_dq_oe(dq_oe1), .sram_we_n(we_n1), .sram_oe_n(oe_n1)
  );

  // Asynchronous SRAM models: combinational read, write while we_n is low.
  logic [15:0] mem0 [0:1023];
  logic [15:0] mem1 [0:1023];
  assign dq_in0 = mem0[sram_addr0[9:0]];
  assign dq_in1 = mem1[sram_addr1[9:0]];
  always @(posedge clk) begin
    if (!we_n0) mem0[sram_addr0[9:0]] <= dq_out0;
    if (!we_n1) mem1[sram_addr1[9:0]] <= dq_out1;
  end

  // Word-level reference: expected memory contents and last loaded value.
  logic [31:0] model_mem [int];
  logic [31:0] last_rd0;
  logic [31:0] last_rd1;

  int checks = 0;
  int errors = 0;

  // Per-cycle pin trace of the most recent access.
  logic [17:0] tr_addr [0:15];
  logic [15:0] tr_dq   [0:15];
  logic        tr_we   [0:15];
  logic        tr_oe   [0:15];
  logic        tr_dqoe [0:15];
  logic        tr_rdy  [0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] lo_addr(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return 18'(((off >> 2) & 32'h1FFFF) * 2);
  endfunction

  // Presents a request at cycle 0 and holds it until ready; lat = cycle ready was seen.
  task automatic access(input bit sel, input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    if (sel) begin
      wr_en1 = w; rd_en1 = r; address1 = a; write_data1 = d;
    end else begin
      wr_en0 = w; rd_en0 = r; address0 = a; write_data0 = d;
    end
    lat = -1;
    for (int c = 0; c < 16; c++) begin
      #1;
      tr_addr[c] = sel ? sram_addr1 : sram_addr0;
      tr_dq[c]   = sel ? dq_out1    : dq_out0;
      tr_we[c]   = sel ? we_n1      : we_n0;
      tr_oe[c]   = sel ? oe_n1      : oe_n0;
      tr_dqoe[c] = sel ? dq_oe1     : dq_oe0;
      tr_rdy[c]  = sel ? ready1     : ready0;
      if (tr_rdy[c]) begin
        lat = c;
        break;
      end
      tick();
    end
    tick();
    if (sel) begin
      wr_en1 = 1'b0; rd_en1 = 1'b0;
    end else begin
      wr_en0 = 1'b0; rd_en0 = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int idx;
    bit w;
    logic [31:0] a;
    logic [31:0] d;

    for (int i = 0; i < 1024; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    rst = 1'b1;
    wr_en0 = 0; rd_en0 = 0; address0 = 0; write_data0 = 0;
    wr_en1 = 0; rd_en1 = 0; address1 = 0; write_data1 = 0;
    last_rd0 = '0;
    last_rd1 = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_ready", {31'b0, ready0}, 32'd1);
    check("rst_we_n", {31'b0, we_n0}, 32'd1);
    check("rst_oe_n", {31'b0, oe_n0}, 32'd1);
    check("rst_dq_oe", {31'b0, dq_oe0}, 32'd0);
    check("rst_dq_out", {16'b0, dq_out0}, 32'd0);
    check("rst_addr", {14'b0, sram_addr0}, 32'd0);
    check("rst_rdata", read_data0, 32'd0);

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      check("idle_pins", {29'b0, ready0, we_n0, dq_oe0}, 32'b110);
    end
    tick();

    // Store 0xDEADBEEF at 1024
    access(0, 1, 0, 32'd1024, 32'hDEADBEEF, lat);
    model_mem[0] = 32'hDEADBEEF;
    check("st_lat", lat, 32'd5);
    for (int c = 0; c < 5; c++) check("st_ready_low", {31'b0, tr_rdy[c]}, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      check("st_addr", {14'b0, tr_addr[c]}, (c < 3) ? 32'd0 : 32'd1);
      check("st_dq", {16'b0, tr_dq[c]}, (c < 3) ? 32'hBEEF : 32'hDEAD);
      check("st_we_oe", {30'b0, tr_we[c], tr_dqoe[c]}, 32'b01);
    end
    check("st_done_we", {31'b0, tr_we[5]}, 32'd1);
    check("st_rdata_kept", read_data0, last_rd0);

    // Load it back
    access(0, 0, 1, 32'd1024, 32'h0, lat);
    last_rd0 = model_mem[0];
    check("ld_lat", lat, 32'd5);
    check("ld_data", read_data0, 32'hDEADBEEF);
    check("ld_oe_lo", {31'b0, tr_oe[2]}, 32'd0);
    check("ld_oe_hi", {31'b0, tr_oe[4]}, 32'd0);

    // Load at 1032 maps to half-words 4 and 5
    access(0, 0, 1, 32'd1032, 32'h0, lat);
    last_rd0 = 32'h0;
    check("ld1032_addr_lo", {14'b0, tr_addr[1]}, 32'd4);
    check("ld1032_addr_hi", {14'b0, tr_addr[3]}, 32'd5);
    check("ld1032_data", read_data0, last_rd0);

    // Simultaneous rd_en and wr_en behaves as a write
    access(0, 1, 1, 32'd1028, 32'h12345678, lat);
    model_mem[1] = 32'h12345678;
    check("both_lat", lat, 32'd5);
    check("both_lo", {13'b0, tr_addr[1], tr_we[1]}, {13'b0, 18'd2, 1'b0});
    check("both_hi", {13'b0, tr_addr[3], tr_we[3]}, {13'b0, 18'd3, 1'b0});
    check("both_oe_n", {31'b0, tr_oe[2]}, 32'd1);
    check("both_rdata", read_data0, last_rd0);

    // Reset during HI of a write aborts it
    wr_en0 = 1'b1; address0 = 32'd1824; write_data0 = 32'hA5A5_5A5A;
    tick(); tick(); tick();
    #1;
    check("abort_in_hi", {13'b0, sram_addr0, we_n0}, {13'b0, lo_addr(32'd1824) + 18'd1, 1'b0});
    rst = 1'b1;
    wr_en0 = 1'b0;
    tick();
    #1;
    last_rd0 = '0;
    check("abort_pins", {29'b0, we_n0, dq_oe0, ready0}, 32'b101);
    check("abort_rdata", read_data0, 32'd0);
    rst = 1'b0;
    tick();
    access(0, 0, 1, 32'd1024, 32'h0, lat);
    last_rd0 = model_mem[0];
    check("post_rst_lat", lat, 32'd5);
    check("post_rst_data", read_data0, last_rd0);

    // Randomized traffic on the WAIT_CYCLES=1 controller
    for (int n = 0; n < 40; n++) begin
      w   = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 63));
      a   = BASE + 4 * idx;
      d   = $urandom;
      access(0, w, !w, a, d, lat);
      check("rnd_lat", lat, 32'd5);
      check("rnd_addr", {14'b0, tr_addr[1]}, {14'b0, lo_addr(a)});
      if (w) begin
        model_mem[idx] = d;
      end else begin
        last_rd0 = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      end
      check(w ? "rnd_wr_rdata" : "rnd_rd_data", read_data0, last_rd0);
    end

    // WAIT_CYCLES=0: one clock per half, ready at cycle 3
    access(1, 1, 0, 32'd1024, 32'hCAFEF00D, lat);
    check("w0_st_lat", lat, 32'd3);
    access(1, 0, 1, 32'd1024, 32'h0, lat);
    last_rd1 = 32'hCAFEF00D;
    check("w0_ld_lat", lat, 32'd3);
    check("w0_ld_addr", {12'b0, tr_addr[1], tr_addr[2]}, {12'b0, 18'd0, 18'd1});
    check("w0_ld_data", read_data1, last_rd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
